// File: rtl/uart_pkg.sv
// Shared types and constants for the host-command UART receiver.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam int unsigned DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4,
        PARITY    = 3'd5
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous single-bit inputs (rx, external triggers).
module sync_ff #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: delivers good bytes with a one-cycle strobe, flags bad stop bits.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_byte_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 byte_ready,
    output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy,
    output logic [2:0]           cs_out
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 byte_ready_q;
    logic                 ferr_q;
    logic                 busy_q;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit_q;
    logic                 perr_q;
`endif

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_rx_sync (
        .clk_i (clock),
        .rst_ni(reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_ready_q <= 1'b0;
            ferr_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            perr_q       <= 1'b0;
`endif
        end else begin
            byte_ready_q <= 1'b0;
            ferr_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q        <= '0;
                        parity_bit_q <= rx_s;
                        state_q      <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data plus parity bit must hold an even number of ones.
                            if (^{shift_q, parity_bit_q}) begin
                                perr_q <= 1'b1;
                            end else begin
                                byte_q       <= shift_q;
                                byte_ready_q <= 1'b1;
                            end
`else
                            byte_q       <= shift_q;
                            byte_ready_q <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_out      = byte_q;
    assign byte_ready    = byte_ready_q;
    assign framing_error = ferr_q;
    assign busy          = busy_q;
    assign cs_out        = state_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver at CLKS_PER_BIT=16; honours UART_RX_PARITY_EN.
module tb_uart_byte_receiver;

    localparam int unsigned CPB  = 16;
    localparam int unsigned SYNC = 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    // Start edge to stop-bit sample: half a bit plus 8 data (+parity) bits plus the stop bit.
    localparam int unsigned LAT        = CPB / 2 + CPB * (9 + PBITS) + SYNC;
    localparam int unsigned FRAME_CLKS = CPB * (10 + PBITS);

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] byte_out;
    logic       byte_ready;
    logic       framing_error;
    logic       busy;
    logic [2:0] cs_out;
    logic       pe;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    assign pe = parity_error;
`else
    assign pe = 1'b0;
`endif

    typedef enum logic [1:0] {EV_BYTE, EV_FRAME, EV_PARITY} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned last_br_cyc = 0;
    logic [7:0]  model_byte  = 8'h00;
    logic        prev_strobe = 1'b0;

    uart_byte_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .byte_out     (byte_out),
        .byte_ready   (byte_ready),
        .framing_error(framing_error),
`ifdef UART_RX_PARITY_EN
        .parity_error (parity_error),
`endif
        .busy         (busy),
        .cs_out       (cs_out)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest expected event.
    always @(negedge clock) begin
        ev_t e;
        logic strobe;
        strobe = byte_ready | framing_error | pe;
        if (!reset) begin
            model_byte  = 8'h00;
            prev_strobe = 1'b0;
        end else begin
            if (strobe) begin
                checks++;
                if (prev_strobe || $countones({byte_ready, framing_error, pe}) > 1) begin
                    failures++;
                    $display("FAIL strobe_exclusive br=%0b fe=%0b pe=%0b prev=%0b required single isolated strobe",
                             byte_ready, framing_error, pe, prev_strobe);
                end
            end
            if (byte_ready) begin
                checks++;
                last_br_cyc = cyc;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte_ready byte_out=%02h required no strobe", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_BYTE || byte_out !== e.data) begin
                        failures++;
                        $display("FAIL byte_value got kind=BYTE data=%02h required kind=%0d data=%02h",
                                 byte_out, e.kind, e.data);
                    end
                    model_byte = e.data;
                end
            end
            if (framing_error) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_framing_error byte_out=%02h required no strobe", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_FRAME || byte_out !== model_byte) begin
                        failures++;
                        $display("FAIL framing_event got kind=FRAME byte_out=%02h required kind=%0d byte_out=%02h",
                                 byte_out, e.kind, model_byte);
                    end
                end
            end
            if (pe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_parity_error byte_out=%02h required no strobe", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_PARITY || byte_out !== model_byte) begin
                        failures++;
                        $display("FAIL parity_event got kind=PARITY byte_out=%02h required kind=%0d byte_out=%02h",
                                 byte_out, e.kind, model_byte);
                    end
                end
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d required finish before time limit", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        checks++;
        if ({byte_out, byte_ready, framing_error, pe, busy, cs_out} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs byte_out=%02h br=%0b fe=%0b pe=%0b busy=%0b cs=%0d required all zero",
                     byte_out, byte_ready, framing_error, pe, busy, cs_out);
        end
        reset = 1'b1;
        wait_clks(2 * CPB);
        checks++;
        if (cs_out !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle cs=%0d busy=%0b required cs=0 busy=0", cs_out, busy);
        end
    endtask

    task automatic test_single_byte;
        int unsigned start_c;
        int unsigned lat;
        exp_q.push_back('{kind: EV_BYTE, data: 8'hA5});
        start_c = cyc;
        send_frame(8'hA5, ^8'hA5, 1'b1);
        wait_clks(CPB);
        lat = last_br_cyc - start_c;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_pending got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            failures++;
            $display("FAIL single_latency got %0d clocks required %0d +/-1", lat, LAT);
        end
        checks++;
        if (byte_out !== 8'hA5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold byte_out=%02h busy=%0b required a5 busy=0", byte_out, busy);
        end
    endtask

    task automatic test_glitch;
        int unsigned start_c;
        logic saw_start;
        saw_start = 1'b0;
        start_c   = cyc;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clks(1);
            if (cs_out == 3'd1) saw_start = 1'b1;
        end
        rx = 1'b1;
        while (cyc - start_c < 8 + SYNC + 2) begin
            wait_clks(1);
            if (cs_out == 3'd1) saw_start = 1'b1;
        end
        checks++;
        if (saw_start !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start_seen got %0b required 1", saw_start);
        end
        checks++;
        if (cs_out !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_return cs=%0d busy=%0b required cs=0 busy=0", cs_out, busy);
        end
        wait_clks(2 * CPB);
        checks++;
        if (byte_out !== 8'hA5 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_no_byte byte_out=%02h pending=%0d required a5 0", byte_out, exp_q.size());
        end
    endtask

    task automatic test_framing;
        exp_q.push_back('{kind: EV_FRAME, data: 8'h3C});
        send_frame(8'h3C, ^8'h3C, 1'b0);
        wait_clks(40);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL framing_pending got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (cs_out !== 3'd4 || busy !== 1'b1 || byte_out !== 8'hA5) begin
            failures++;
            $display("FAIL framing_wait cs=%0d busy=%0b byte_out=%02h required cs=4 busy=1 a5",
                     cs_out, busy, byte_out);
        end
        rx = 1'b1;
        wait_clks(SYNC + 3);
        checks++;
        if (cs_out !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL framing_recover cs=%0d busy=%0b required cs=0 busy=0", cs_out, busy);
        end
        wait_clks(2 * CPB);
    endtask

    task automatic test_back_to_back;
        int unsigned t1;
        int unsigned t2;
        exp_q.push_back('{kind: EV_BYTE, data: 8'h01});
        exp_q.push_back('{kind: EV_BYTE, data: 8'hFF});
        send_frame(8'h01, ^8'h01, 1'b1);
        t1 = last_br_cyc;
        send_frame(8'hFF, ^8'hFF, 1'b1);
        wait_clks(CPB);
        t2 = last_br_cyc;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_pending got %0d pending required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (t2 - t1 != FRAME_CLKS) begin
            failures++;
            $display("FAIL b2b_spacing got %0d clocks required %0d", t2 - t1, FRAME_CLKS);
        end
        checks++;
        if (byte_out !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_last byte_out=%02h required ff", byte_out);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        d = 8'h77;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        wait_clks(CPB / 2);
        reset = 1'b0;
        wait_clks(3);
        checks++;
        if ({byte_out, byte_ready, framing_error, pe, busy, cs_out} !== 15'd0) begin
            failures++;
            $display("FAIL midreset_outputs byte_out=%02h br=%0b fe=%0b pe=%0b busy=%0b cs=%0d required all zero",
                     byte_out, byte_ready, framing_error, pe, busy, cs_out);
        end
        rx = 1'b1;
        wait_clks(2);
        reset = 1'b1;
        wait_clks(FRAME_CLKS);
        checks++;
        if (cs_out !== 3'd0 || byte_out !== 8'h00 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_abort cs=%0d byte_out=%02h pending=%0d required 0 00 0",
                     cs_out, byte_out, exp_q.size());
        end
        exp_q.push_back('{kind: EV_BYTE, data: 8'h5A});
        send_frame(8'h5A, ^8'h5A, 1'b1);
        wait_clks(CPB);
        checks++;
        if (byte_out !== 8'h5A || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_next byte_out=%02h pending=%0d required 5a 0", byte_out, exp_q.size());
            exp_q.delete();
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        exp_q.push_back('{kind: EV_PARITY, data: 8'h07});
        send_frame(8'h07, 1'b0, 1'b1);
        wait_clks(CPB);
        checks++;
        if (byte_out !== 8'h5A || exp_q.size() != 0) begin
            failures++;
            $display("FAIL parity_bad byte_out=%02h pending=%0d required 5a 0", byte_out, exp_q.size());
            exp_q.delete();
        end
        exp_q.push_back('{kind: EV_BYTE, data: 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(CPB);
        checks++;
        if (byte_out !== 8'h07 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL parity_good byte_out=%02h pending=%0d required 07 0", byte_out, exp_q.size());
            exp_q.delete();
        end
        exp_q.push_back('{kind: EV_FRAME, data: 8'h07});
        send_frame(8'h07, 1'b0, 1'b0);
        rx = 1'b1;
        wait_clks(2 * CPB);
        checks++;
        if (cs_out !== 3'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL parity_framing_wins cs=%0d pending=%0d required 0 0", cs_out, exp_q.size());
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        wait_clks(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
